// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: state codes, opcode constants and strobe bundle shared by the sequencer and its benches.
package cpu_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_e;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;
  typedef struct packed {
    logic ir_we;
    logic pc_we;
    logic reg_we;
    logic mem_rd;
    logic mem_we;
    logic alu_src;
    logic mem_to_reg;
    logic reg_dst;
    logic branch;
  } strobes_t;
endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with Moore strobes and a retired counter.
// Optional single-step handshake enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [1:0] opcode,
  input  logic       run,
  input  logic       step_req,
  output logic       step_ack,
  input  logic       halt_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       branch,
  output logic [2:0] state,
  output logic       busy,
  output logic [7:0] retired
);
  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] wait_q, wait_d;
  logic [7:0] retired_q;
  logic       done, step_go, step_mode;
  strobes_t   s;
`ifdef SEQ_SINGLE_STEP_EN
  logic step_q, ack_q, armed_q;
  assign step_go   = state_q == IDLE && !run && !halt_req && step_req && armed_q;
  assign step_mode = step_q;
  assign step_ack  = ack_q;
  // armed_q requires step_req to be seen low in IDLE before another step may start
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      step_q  <= 1'b0;
      ack_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      step_q  <= step_go ? 1'b1 : done ? 1'b0 : step_q;
      ack_q   <= done && step_q;
      armed_q <= (!step_req && state_q == IDLE) ? 1'b1 : step_go ? 1'b0 : armed_q;
    end
`else
  assign step_go   = 1'b0;
  assign step_mode = 1'b0;
  assign step_ack  = step_req & 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    done    = 1'b0;
    case (state_q)
      IDLE:   state_d = ((run && !halt_req) || step_go) ? FETCH : IDLE;
      FETCH:  state_d = DECODE;
      DECODE: begin
        op_d    = opcode;
        state_d = EXEC;
      end
      EXEC: begin
        done    = op_q == OP_J;
        state_d = op_q == OP_ADD ? WB : MEM;
        wait_d  = 3'(MEM_WAIT);
      end
      MEM: begin
        wait_d  = wait_q - 3'd1;
        done    = wait_q == 3'd0 && op_q == OP_SW;
        state_d = wait_q != 3'd0 ? MEM : WB;
      end
      WB:      done = 1'b1;
      default: state_d = IDLE;
    endcase
    if (done) state_d = (run && !halt_req && !step_mode) ? FETCH : IDLE;
  end
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      wait_q    <= 3'd0;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_q + {7'd0, done};
    end
  always_comb begin
    s            = '0;
    s.ir_we      = state_q == FETCH;
    s.pc_we      = done;
    s.reg_we     = state_q == WB;
    s.mem_rd     = state_q == MEM && op_q == OP_LW;
    s.mem_we     = state_q == MEM && op_q == OP_SW;
    s.alu_src    = state_q == EXEC && (op_q == OP_LW || op_q == OP_SW);
    s.mem_to_reg = state_q == WB && op_q == OP_LW;
    s.reg_dst    = state_q == WB && op_q == OP_ADD;
    s.branch     = state_q == EXEC && op_q == OP_J;
  end
  assign {ir_we, pc_we, reg_we, mem_rd, mem_we, alu_src, mem_to_reg, reg_dst, branch} = s;
  assign state   = state_q;
  assign busy    = state_q != IDLE;
  assign retired = retired_q;
endmodule
